// File: rtl/comp_pipe.sv
// comp_pipe -- pipelined magnitude comparator with result counters.
//
// Compares two WIDTH-bit operands CHUNK bits at a time, MSB chunk first,
// one chunk per register stage, so a new operand pair can enter every cycle.
// The final stage feeds an output register holding out_valid and one-hot
// agtb/aeqb/altb flags. Three saturating counters tally the delivered
// results by outcome.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, signed_mode)
//   a, b                : WIDTH-bit operands
//   signed_mode         : 1 = two's-complement compare, 0 = unsigned
//   out_valid/out_ready : result handshake (agtb, aeqb, altb)
//   clr_cnt             : synchronous clear of the result counters
//   gt_cnt/eq_cnt/lt_cnt: saturating counts of delivered results
module comp_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             agtb,
  output logic             aeqb,
  output logic             altb,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             advance_s;
  logic [WIDTH-1:0] a_mod_s;
  logic [WIDTH-1:0] b_mod_s;

  logic out_valid_q, out_valid_d;
  logic agtb_q, agtb_d;
  logic aeqb_q, aeqb_d;
  logic altb_q, altb_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic hs_out_s;

  // Whole pipeline moves together; a stalled output freezes every stage.
  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = advance_s;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_mod_s = signed_mode ? (a ^ MSB_MASK) : a;
  assign b_mod_s = signed_mode ? (b ^ MSB_MASK) : b;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    logic             vld_q, vld_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             sm_q, sm_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic             src_vld_s, src_gt_s, src_eq_s, src_sm_s;
    logic [WIDTH-1:0] src_a_s, src_b_s;
    logic [CHUNK-1:0] ca_s, cb_s;

    if (k == 0) begin : g_src_in
      assign src_vld_s = in_valid;
      assign src_gt_s  = 1'b0;
      assign src_eq_s  = 1'b1;
      assign src_sm_s  = signed_mode;
      assign src_a_s   = a_mod_s;
      assign src_b_s   = b_mod_s;
    end else begin : g_src_prev
      assign src_vld_s = g_stage[k-1].vld_q;
      assign src_gt_s  = g_stage[k-1].gt_q;
      assign src_eq_s  = g_stage[k-1].eq_q;
      assign src_sm_s  = g_stage[k-1].sm_q;
      assign src_a_s   = g_stage[k-1].a_q;
      assign src_b_s   = g_stage[k-1].b_q;
    end

    // Operands are shifted left each stage, so the chunk to resolve is always on top.
    assign ca_s = src_a_s[WIDTH-1 -: CHUNK];
    assign cb_s = src_b_s[WIDTH-1 -: CHUNK];

    // Next-state for this stage: resolve one chunk while still equal, else hold.
    always_comb begin
      vld_d = vld_q;
      gt_d  = gt_q;
      eq_d  = eq_q;
      sm_d  = sm_q;
      a_d   = a_q;
      b_d   = b_q;
      if (advance_s) begin
        vld_d = src_vld_s;
        sm_d  = src_sm_s;
        a_d   = src_a_s << CHUNK;
        b_d   = src_b_s << CHUNK;
        gt_d  = src_gt_s;
        eq_d  = src_eq_s;
        if (src_eq_s) begin
          if (ca_s > cb_s) begin
            gt_d = 1'b1;
            eq_d = 1'b0;
          end else if (ca_s < cb_s) begin
            eq_d = 1'b0;
          end else begin
            eq_d = 1'b1;
          end
        end else begin
          eq_d = 1'b0;
        end
      end else begin
        vld_d = vld_q;
      end
    end

    // Stage valid bit, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
    end

    // Stage payload; meaningless while the valid bit is low, so no reset.
    always_ff @(posedge clk) begin
      gt_q <= gt_d;
      eq_q <= eq_d;
      sm_q <= sm_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  // Last stage has fully consumed its operands; keep them from dangling.
  logic unused_tail_s;
  assign unused_tail_s = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q,
                           g_stage[STAGES-1].sm_q};

  // Output register: flags are forced low whenever no result is present.
  always_comb begin
    out_valid_d = out_valid_q;
    agtb_d      = agtb_q;
    aeqb_d      = aeqb_q;
    altb_d      = altb_q;
    if (advance_s) begin
      out_valid_d = g_stage[STAGES-1].vld_q;
      agtb_d      = g_stage[STAGES-1].vld_q & g_stage[STAGES-1].gt_q;
      aeqb_d      = g_stage[STAGES-1].vld_q & g_stage[STAGES-1].eq_q;
      altb_d      = g_stage[STAGES-1].vld_q & !g_stage[STAGES-1].gt_q
                    & !g_stage[STAGES-1].eq_q;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  assign hs_out_s = out_valid_q & out_ready;

  // Counter next-state: clear beats a same-cycle delivery; saturate at max.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    lt_cnt_d = lt_cnt_q;
    if (clr_cnt) begin
      gt_cnt_d = '0;
      eq_cnt_d = '0;
      lt_cnt_d = '0;
    end else if (hs_out_s) begin
      if (agtb_q && (gt_cnt_q != CNT_MAX)) begin
        gt_cnt_d = gt_cnt_q + CNT_ONE;
      end else if (aeqb_q && (eq_cnt_q != CNT_MAX)) begin
        eq_cnt_d = eq_cnt_q + CNT_ONE;
      end else if (altb_q && (lt_cnt_q != CNT_MAX)) begin
        lt_cnt_d = lt_cnt_q + CNT_ONE;
      end else begin
        gt_cnt_d = gt_cnt_q;
      end
    end else begin
      gt_cnt_d = gt_cnt_q;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      agtb_q      <= 1'b0;
      aeqb_q      <= 1'b0;
      altb_q      <= 1'b0;
      gt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
      lt_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      agtb_q      <= agtb_d;
      aeqb_q      <= aeqb_d;
      altb_q      <= altb_d;
      gt_cnt_q    <= gt_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
      lt_cnt_q    <= lt_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign agtb      = agtb_q;
  assign aeqb      = aeqb_q;
  assign altb      = altb_q;
  assign gt_cnt    = gt_cnt_q;
  assign eq_cnt    = eq_cnt_q;
  assign lt_cnt    = lt_cnt_q;

endmodule
